// File: rtl/axil_adder_initiator.sv
`default_nettype none
// ============================================================================
// Module      : axil_adder_initiator
// Description : AXI-Lite initiator for the adder register block. Takes an
//               operand pair on a valid/ready command port, writes it to the
//               adder, waits a programmable settle delay, reads back the sum
//               and returns it with an error flag on a valid/ready response
//               port. Every bus wait is bounded by a timeout that aborts the
//               transaction and reports an error.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_adder_initiator #(
    parameter logic [31:0] ADDER_ADDR     = 32'h0000_0500,
    parameter int          SETTLE_CYCLES  = 2,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_sync,

    // command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,

    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_sum,
    output logic        rsp_err,

    // AXI-Lite write address channel
    output logic        awvalid,
    output logic [31:0] awaddr,
    input  logic        awready,

    // AXI-Lite write data channel
    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        wready,

    // AXI-Lite write response channel
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,

    // AXI-Lite read address channel
    output logic        arvalid,
    output logic [31:0] araddr,
    input  logic        arready,

    // AXI-Lite read data channel
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        rready
);

    // Timeout counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int                 C_TMO_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [C_TMO_W-1:0] C_TMO_MAX     = C_TMO_W'(TIMEOUT_CYCLES - 1);
    // SETTLE spends exactly SETTLE_CYCLES cycles counting down to zero.
    localparam logic [3:0]         C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam bit                 C_SETTLE_SKIP = (SETTLE_CYCLES == 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_SETTLE  = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [C_TMO_W-1:0]   r_tmo_cnt;
    logic [3:0]           r_settle_cnt;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic                 r_err;
    logic                 r_cmd_ready;
    logic                 r_rsp_valid;
    logic [4:0]           r_rsp_sum;
    logic                 r_rsp_err;
    logic                 r_awvalid;
    logic [31:0]          r_awaddr;
    logic                 r_wvalid;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic                 r_bready;
    logic                 r_arvalid;
    logic [31:0]          r_araddr;
    logic                 r_rready;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [C_TMO_W-1:0]   w_tmo_cnt_nxt;
    logic [3:0]           w_settle_cnt_nxt;
    logic                 w_aw_done_nxt;
    logic                 w_w_done_nxt;
    logic                 w_err_nxt;
    logic                 w_cmd_ready_nxt;
    logic                 w_rsp_valid_nxt;
    logic [4:0]           w_rsp_sum_nxt;
    logic                 w_rsp_err_nxt;
    logic                 w_awvalid_nxt;
    logic [31:0]          w_awaddr_nxt;
    logic                 w_wvalid_nxt;
    logic [31:0]          w_wdata_nxt;
    logic [3:0]           w_wstrb_nxt;
    logic                 w_bready_nxt;
    logic                 w_arvalid_nxt;
    logic [31:0]          w_araddr_nxt;
    logic                 w_rready_nxt;
    logic                 w_abort;

    // Handshake and timeout qualifiers
    logic w_cmd_fire;
    logic w_rsp_fire;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_b_fire;
    logic w_ar_fire;
    logic w_r_fire;
    logic w_aw_done_now;
    logic w_w_done_now;
    logic w_tmo_hit;
    logic w_unused_rdata;

    assign w_cmd_fire    = cmd_valid & r_cmd_ready;
    assign w_rsp_fire    = r_rsp_valid & rsp_ready;
    assign w_aw_fire     = r_awvalid & awready;
    assign w_w_fire      = r_wvalid & wready;
    assign w_b_fire      = bvalid & r_bready;
    assign w_ar_fire     = r_arvalid & arready;
    assign w_r_fire      = rvalid & r_rready;
    assign w_aw_done_now = r_aw_done | w_aw_fire;
    assign w_w_done_now  = r_w_done | w_w_fire;
    assign w_tmo_hit     = (r_tmo_cnt == C_TMO_MAX);

    // Only the low five bits of read data carry the sum.
    assign w_unused_rdata = ^rdata[31:5];

    // Next-state and output decode; a completed handshake always wins over a
    // timeout landing in the same cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_tmo_cnt_nxt    = r_tmo_cnt;
        w_settle_cnt_nxt = r_settle_cnt;
        w_aw_done_nxt    = r_aw_done;
        w_w_done_nxt     = r_w_done;
        w_err_nxt        = r_err;
        w_cmd_ready_nxt  = r_cmd_ready;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_sum_nxt    = r_rsp_sum;
        w_rsp_err_nxt    = r_rsp_err;
        w_awvalid_nxt    = r_awvalid;
        w_awaddr_nxt     = r_awaddr;
        w_wvalid_nxt     = r_wvalid;
        w_wdata_nxt      = r_wdata;
        w_wstrb_nxt      = r_wstrb;
        w_bready_nxt     = r_bready;
        w_arvalid_nxt    = r_arvalid;
        w_araddr_nxt     = r_araddr;
        w_rready_nxt     = r_rready;
        w_abort          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (w_cmd_fire) begin
                    // Operands land on the bus together with both valids.
                    w_wdata_nxt     = {24'b0, cmd_b, cmd_a};
                    w_wstrb_nxt     = 4'hF;
                    w_awaddr_nxt    = ADDER_ADDR;
                    w_awvalid_nxt   = 1'b1;
                    w_wvalid_nxt    = 1'b1;
                    w_cmd_ready_nxt = 1'b0;
                    w_aw_done_nxt   = 1'b0;
                    w_w_done_nxt    = 1'b0;
                    w_err_nxt       = 1'b0;
                    w_state_nxt     = S_WR;
                end
            end

            S_WR: begin
                // AW and W retire independently; each valid drops once taken.
                if (w_aw_fire) begin
                    w_awvalid_nxt = 1'b0;
                end
                if (w_w_fire) begin
                    w_wvalid_nxt = 1'b0;
                end
                w_aw_done_nxt = w_aw_done_now;
                w_w_done_nxt  = w_w_done_now;
                if (w_aw_done_now && w_w_done_now) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_WR_RESP;
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end

            S_WR_RESP: begin
                if (w_b_fire) begin
                    w_err_nxt    = (bresp != 2'b00);
                    w_bready_nxt = 1'b0;
                    if (C_SETTLE_SKIP) begin
                        w_araddr_nxt  = ADDER_ADDR;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = S_RD_ADDR;
                    end else begin
                        w_settle_cnt_nxt = C_SETTLE_LOAD;
                        w_state_nxt      = S_SETTLE;
                    end
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end

            S_SETTLE: begin
                // Give the adder's registered result time to update.
                if (r_settle_cnt == 4'd0) begin
                    w_araddr_nxt  = ADDER_ADDR;
                    w_arvalid_nxt = 1'b1;
                    w_state_nxt   = S_RD_ADDR;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt - 4'd1;
                end
            end

            S_RD_ADDR: begin
                if (w_ar_fire) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_DATA;
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end

            S_RD_DATA: begin
                if (w_r_fire) begin
                    w_rsp_sum_nxt   = rdata[4:0];
                    w_rsp_err_nxt   = r_err | (rresp != 2'b00);
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end

            S_RESP: begin
                // Response is held untouched until the sequencer takes it.
                if (w_rsp_fire) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Timeout recovery: withdraw everything on the bus and report error.
        if (w_abort) begin
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_sum_nxt   = 5'd0;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RESP;
        end

        // Timeout count restarts on every state entry and only runs while
        // waiting on the bus.
        if (w_state_nxt != r_state) begin
            w_tmo_cnt_nxt = '0;
        end else if (r_state inside {S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA}) begin
            w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end else begin
            w_tmo_cnt_nxt = '0;
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            r_state      <= S_IDLE;
            r_tmo_cnt    <= '0;
            r_settle_cnt <= 4'd0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_err        <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_sum    <= 5'd0;
            r_rsp_err    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_awaddr     <= 32'd0;
            r_wvalid     <= 1'b0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'd0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= 32'd0;
            r_rready     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_aw_done    <= w_aw_done_nxt;
            r_w_done     <= w_w_done_nxt;
            r_err        <= w_err_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_sum    <= w_rsp_sum_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_awaddr     <= w_awaddr_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wstrb      <= w_wstrb_nxt;
            r_bready     <= w_bready_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_araddr     <= w_araddr_nxt;
            r_rready     <= w_rready_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_err   = r_rsp_err;
    assign awvalid   = r_awvalid;
    assign awaddr    = r_awaddr;
    assign wvalid    = r_wvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign bready    = r_bready;
    assign arvalid   = r_arvalid;
    assign araddr    = r_araddr;
    assign rready    = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_adder_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_adder_initiator
// Description : Directed bench for axil_adder_initiator: a table of single
//               transactions against a configurable AXI-Lite slave, then
//               response back-pressure, read timeout and mid-write reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_adder_initiator;

    localparam logic [31:0] C_ADDR   = 32'h0000_0500;
    localparam int          C_SETTLE = 2;
    localparam int          C_TMO    = 16;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_sync;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_a;
    logic [3:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_sum;
    logic        rsp_err;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    always #5 clk_main_a0 = ~clk_main_a0;

    axil_adder_initiator #(
        .ADDER_ADDR     (C_ADDR),
        .SETTLE_CYCLES  (C_SETTLE),
        .TIMEOUT_CYCLES (C_TMO)
    ) u_dut (
        .clk_main_a0   (clk_main_a0),
        .rst_main_sync (rst_main_sync),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_sum       (rsp_sum),
        .rsp_err       (rsp_err),
        .awvalid       (awvalid),
        .awaddr        (awaddr),
        .awready       (awready),
        .wvalid        (wvalid),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wready        (wready),
        .bvalid        (bvalid),
        .bresp         (bresp),
        .bready        (bready),
        .arvalid       (arvalid),
        .araddr        (araddr),
        .arready       (arready),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .rresp         (rresp),
        .rready        (rready)
    );

    // ------------------------------------------------------------------
    // Slave configuration and bookkeeping
    // ------------------------------------------------------------------
    int          cfg_aw_delay = 0;
    int          cfg_w_delay  = 0;
    logic [1:0]  cfg_bresp    = 2'b00;
    logic [1:0]  cfg_rresp    = 2'b00;
    logic [31:0] cfg_rdata    = 32'd0;
    bit          cfg_r_never  = 1'b0;

    int          cyc = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0;
    int          b_cyc = 0, ar_cyc = 0, ar_rise_cyc = 0, rsp_rise_cyc = 0;
    int          proto_viol = 0;
    bit          aw_got = 0, w_got = 0, r_pend = 0;
    bit          ar_prev = 0, rsp_prev = 0, wv_prev = 0;
    logic [31:0] wd_prev = 0;
    logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
    logic [3:0]  last_wstrb = 0;
    int          aw_wait = 0, w_wait = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Bus monitor: counts handshakes and flags ordering/stability breaches.
    always @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            aw_got = 0; w_got = 0; r_pend = 0;
            ar_prev = 0; rsp_prev = 0; wv_prev = 0;
        end else begin
            if (arvalid && (bready || aw_got || w_got)) proto_viol++;
            if (awvalid && awaddr != C_ADDR) proto_viol++;
            if (arvalid && araddr != C_ADDR) proto_viol++;
            if (wvalid && wv_prev && wdata != wd_prev) proto_viol++;
            if (awvalid && awready) begin aw_hs++; aw_got = 1; last_awaddr = awaddr; end
            if (wvalid && wready) begin
                w_hs++; w_got = 1; last_wdata = wdata; last_wstrb = wstrb;
            end
            if (bvalid && bready) begin b_cyc = cyc; aw_got = 0; w_got = 0; end
            if (arvalid && !ar_prev) ar_rise_cyc = cyc;
            if (arvalid && arready) begin ar_hs++; ar_cyc = cyc; r_pend = 1; last_araddr = araddr; end
            if (rvalid && rready) r_pend = 0;
            if (rsp_valid && !rsp_prev) rsp_rise_cyc = cyc;
            ar_prev  = arvalid;
            rsp_prev = rsp_valid;
            wv_prev  = wvalid;
            wd_prev  = wdata;
        end
        cyc++;
    end

    // Slave responder, driven on the falling edge.
    always @(negedge clk_main_a0) begin
        if (rst_main_sync) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_wait = 0; w_wait = 0;
        end else begin
            if (awvalid) begin awready = (aw_wait >= cfg_aw_delay); aw_wait++; end
            else begin awready = 0; aw_wait = 0; end
            if (wvalid) begin wready = (w_wait >= cfg_w_delay); w_wait++; end
            else begin wready = 0; w_wait = 0; end
            bvalid  = aw_got && w_got;
            arready = arvalid;
            rvalid  = r_pend && !cfg_r_never;
        end
        bresp = cfg_bresp;
        rresp = cfg_rresp;
        rdata = cfg_rdata;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main_a0);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        while (!cmd_ready && n < 40) begin tick(); n++; end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin tick(); n++; end
        check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic [4:0]  exp_sum;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base_aw, base_w, base_ar, base_pv, bad;
        logic [112:0] all_outs;

        vecs[0] = '{4'h3, 4'h5, 0, 0, 2'b00, 2'b00, 32'h0000_0008, 32'h0000_0053, 5'd8,  1'b0};
        vecs[1] = '{4'hF, 4'hF, 3, 0, 2'b00, 2'b00, 32'h0000_001E, 32'h0000_00FF, 5'd30, 1'b0};
        vecs[2] = '{4'h3, 4'h4, 0, 0, 2'b10, 2'b00, 32'h0000_0007, 32'h0000_0043, 5'd7,  1'b1};
        vecs[3] = '{4'h0, 4'h0, 0, 2, 2'b00, 2'b11, 32'hDEAD_BEE0, 32'h0000_0000, 5'd0,  1'b1};
        vecs[4] = '{4'h9, 4'h6, 1, 1, 2'b00, 2'b00, 32'hFFFF_FFEF, 32'h0000_0069, 5'd15, 1'b0};
        vecs[5] = '{4'h1, 4'hE, 2, 2, 2'b00, 2'b00, 32'hABCD_EF0F, 32'h0000_00E1, 5'd15, 1'b0};

        // Reset state
        rst_main_sync = 1'b1; cmd_valid = 1'b0; cmd_a = 4'h0; cmd_b = 4'h0; rsp_ready = 1'b0;
        tick(); tick(); tick();
        all_outs = {cmd_ready, rsp_valid, rsp_sum, rsp_err, awvalid, awaddr, wvalid, wdata,
                    wstrb, bready, arvalid, araddr, rready};
        check("reset_outputs_zero", 32'(|all_outs), 32'd0);
        rst_main_sync = 1'b0;
        tick();
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

        // Table of single transactions
        for (int i = 0; i < 6; i++) begin
            cfg_aw_delay = vecs[i].aw_dly;
            cfg_w_delay  = vecs[i].w_dly;
            cfg_bresp    = vecs[i].bresp;
            cfg_rresp    = vecs[i].rresp;
            cfg_rdata    = vecs[i].rdata;
            base_aw = aw_hs; base_w = w_hs; base_ar = ar_hs; base_pv = proto_viol;
            send_cmd(vecs[i].a, vecs[i].b);
            wait_rsp();
            check($sformatf("v%0d_rsp_sum", i), 32'(rsp_sum), 32'(vecs[i].exp_sum));
            check($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_wstrb", i), 32'(last_wstrb), 32'hF);
            check($sformatf("v%0d_awaddr", i), last_awaddr, C_ADDR);
            check($sformatf("v%0d_araddr", i), last_araddr, C_ADDR);
            check($sformatf("v%0d_aw_beats", i), 32'(aw_hs - base_aw), 32'd1);
            check($sformatf("v%0d_w_beats", i), 32'(w_hs - base_w), 32'd1);
            check($sformatf("v%0d_ar_beats", i), 32'(ar_hs - base_ar), 32'd1);
            check($sformatf("v%0d_settle_gap", i), 32'(ar_rise_cyc - b_cyc), 32'(C_SETTLE + 1));
            check($sformatf("v%0d_protocol", i), 32'(proto_viol - base_pv), 32'd0);
            check($sformatf("v%0d_cmd_ready_busy", i), 32'(cmd_ready), 32'd0);
            accept_rsp();
        end

        // Response back-pressure: everything holds while rsp_ready is low
        cfg_aw_delay = 0; cfg_w_delay = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
        cfg_rdata = 32'h0000_000F;
        send_cmd(4'h7, 4'h8);
        wait_rsp();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("hold_c%0d", k), {24'd0, rsp_valid, rsp_sum, rsp_err, cmd_ready},
                  {24'd0, 1'b1, 5'd15, 1'b0, 1'b0});
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_c1", {30'd0, rsp_valid, cmd_ready}, 32'd0);
        tick();
        check("post_rsp_c2_cmd_ready", 32'(cmd_ready), 32'd1);

        // Read data never arrives: timeout aborts the read
        cfg_r_never = 1'b1;
        cfg_rdata   = 32'h0000_001F;
        send_cmd(4'h2, 4'h2);
        wait_rsp();
        check("tmo_rsp_err", 32'(rsp_err), 32'd1);
        check("tmo_rsp_sum", 32'(rsp_sum), 32'd0);
        check("tmo_rready", 32'(rready), 32'd0);
        tick();
        check("tmo_latency", 32'(rsp_rise_cyc - ar_cyc), 32'(C_TMO + 1));
        accept_rsp();

        // Reset while the write address is stalled
        cfg_aw_delay = 20;
        send_cmd(4'h4, 4'h4);
        check("rst_pre_awvalid", 32'(awvalid), 32'd1);
        tick();
        rst_main_sync = 1'b1;
        tick();
        all_outs = {cmd_ready, rsp_valid, rsp_sum, rsp_err, awvalid, awaddr, wvalid, wdata,
                    wstrb, bready, arvalid, araddr, rready};
        check("midrst_outputs_zero", 32'(|all_outs), 32'd0);
        rst_main_sync = 1'b0;
        cfg_r_never  = 1'b0;
        cfg_aw_delay = 0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rsp_valid || awvalid) bad++;
        end
        check("midrst_no_response", 32'(bad), 32'd0);

        cfg_rdata = 32'h0000_000B;
        base_aw = aw_hs; base_ar = ar_hs;
        send_cmd(4'h6, 4'h5);
        wait_rsp();
        check("after_rst_sum", 32'(rsp_sum), 32'd11);
        check("after_rst_err", 32'(rsp_err), 32'd0);
        check("after_rst_beats", 32'((aw_hs - base_aw) + (ar_hs - base_ar)), 32'd2);
        accept_rsp();

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_adder_initiator.md
Name: axil_adder_initiator

Overview:
- AXI-Lite initiator that drives the adder register block over the OCL-style register interface.
- Accepts an operand pair on a valid/ready command port, then runs four steps: a single-beat write of the operands, a programmable settle delay, a single-beat read of the result, and a return of the sum and an error flag on a valid/ready response port.
- Sits between a test/control sequencer and the slave side of the adder path; used for on-chip self-test and for simulation-side bus exercise.

Parameters:
- ADDER_ADDR, 32'h0000_0500, address used for both the operand write and the result read.
- SETTLE_CYCLES, 2, idle cycles between the B handshake and AR assertion; covers the adder's registered latency. Range 0..15.
- TIMEOUT_CYCLES, 256, maximum cycles waited in any bus state before aborting. Must be ≥ 2.

Ports:
- clk_main_a0  in  1  clock
- rst_main_sync  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_a  in  4  operand 1
- cmd_b  in  4  operand 2
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_sum  out  5  sum read back, rdata[4:0]
- rsp_err  out  1  nonzero BRESP/RRESP, or timeout
- awvalid  out  1
- awaddr  out  32
- awready  in  1
- wvalid  out  1
- wdata  out  32
- wstrb  out  4
- wready  in  1
- bvalid  in  1
- bresp  in  2
- bready  out  1
- arvalid  out  1
- araddr  out  32
- arready  in  1
- rvalid  in  1
- rdata  in  32
- rresp  in  2
- rready  out  1

Behaviour:
- Reset (synchronous, rst_main_sync=1 at a clock edge):
  - All outputs go to 0: cmd_ready, rsp_valid, rsp_sum, rsp_err, all valids, bready, rready, awaddr, araddr, wdata, wstrb.
  - State goes to IDLE; the timeout counter and settle counter clear.
  - Reset mid-transaction aborts immediately and sends no response.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready: latch operands; drive wdata={24'b0,cmd_b,cmd_a}, wstrb=4'hF, awaddr=ADDER_ADDR.
  - Next cycle: awvalid=1, wvalid=1, cmd_ready=0; go to WR.
- WR:
  - AW and W complete independently. awvalid drops the cycle after awready is sampled high; wvalid drops the cycle after wready is sampled high.
  - Both may complete in the same cycle.
  - When both have completed, assert bready=1 and go to WR_RESP.
- WR_RESP:
  - On bvalid & bready: latch err=(bresp!=0), set bready=0, load the settle counter, go to SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then set araddr=ADDER_ADDR, arvalid=1, go to RD_ADDR.
  - With SETTLE_CYCLES=0, arvalid asserts the cycle after the B handshake.
- RD_ADDR:
  - On arready: arvalid=0, rready=1, go to RD_DATA.
- RD_DATA:
  - On rvalid & rready: rsp_sum=rdata[4:0]; rsp_err = latched err | (rresp!=0); rready=0; rsp_valid=1; go to RESP.
  - rdata[31:5] is ignored.
- RESP:
  - Hold rsp_valid, rsp_sum and rsp_err stable until rsp_ready.
  - Then rsp_valid=0 and go to IDLE; cmd_ready=1 on the following cycle. There is no command/response overlap.
- Timeout:
  - The counter clears on every state entry and increments each cycle in WR, WR_RESP, RD_ADDR and RD_DATA.
  - At TIMEOUT_CYCLES-1: deassert every AXI valid/ready, set rsp_err=1, rsp_sum=0, rsp_valid=1, go to RESP.
  - Deasserting an asserted valid on timeout is the intentional recovery behaviour for this block.
- Ordering and protocol rules:
  - Never more than one outstanding transaction. arvalid is never asserted before the B handshake completes.
  - Address and data outputs are stable while the corresponding valid is high.
- Arithmetic:
  - The block performs no arithmetic; rsp_sum is passed through from the bus.
  - The expected sum is cmd_a+cmd_b with no wrap, range 0..30.

Test Plan:
- a=4'h3, b=4'h5, slave always ready, OKAY responses → wdata=32'h0000_0053, awaddr=araddr=ADDER_ADDR, rsp_sum=5'd8, rsp_err=0, exactly one AW, one W, one AR.
- a=4'hF, b=4'hF, awready delayed 3 cycles, wready delayed 0 → AW and W complete in separate cycles, no duplicate beats, rsp_sum=5'd30.
- bresp=2'b10 on the write, RRESP OKAY, rdata=32'h0000_0007 → rsp_err=1, rsp_sum=5'd7.
- rvalid never asserted, TIMEOUT_CYCLES=16 → rready drops and rsp_valid rises 16 cycles after RD_DATA entry, with rsp_err=1, rsp_sum=0.
- rsp_ready held low 10 cycles → rsp_valid, rsp_sum and rsp_err stable throughout, cmd_ready=0 throughout; cmd_ready=1 two cycles after rsp_ready.
- rst_main_sync pulsed while awvalid=1 → next cycle all outputs 0, no rsp_valid; the next command runs normally.
